// File: rtl/psum_accumulator_pkg.sv
// psum_accumulator_pkg: shared constants and FSM encoding for the psum accumulator slice.
package psum_accumulator_pkg;

   localparam int LANES    = 4;
   localparam int INT8_MAX = 127;
   localparam int INT8_MIN = -128;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/psum_acc_ram.sv
// psum_acc_ram: simple dual-port accumulator buffer, one write port and one synchronous read port.
module psum_acc_ram
   import psum_accumulator_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int AW    = 10,
   parameter int W     = 4 * 20
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   // Write port
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Registered read; a same-cycle write to raddr is covered by the caller's forwarding path
   always_ff @(posedge clk) begin
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/psum_accumulator.sv
// psum_accumulator: sums conv-core partial sums over all input channels of a layer and writes
// clamped (optionally ReLU'd) int8 results, four lanes per word, to the output-feature BRAM.
module psum_accumulator
   import psum_accumulator_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 20,
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       init_signal,
   input  logic [11:0]                cfg_beats,
   input  logic [11:0]                cfg_channel,
   input  logic [ADDR_W-1:0]          cfg_base,
   input  logic                       cfg_relu,
   input  logic signed [DATA_W-1:0]   psum0,
   input  logic signed [DATA_W-1:0]   psum1,
   input  logic signed [DATA_W-1:0]   psum2,
   input  logic signed [DATA_W-1:0]   psum3,
   input  logic                       psum_vld,
   input  logic                       channel_end,
   output logic [ADDR_W-1:0]          bram_addr,
   output logic [LANES*DATA_W-1:0]    bram_din,
   output logic [3:0]                 bram_we,
   output logic                       busy,
   output logic                       layer_done,
   output logic                       err
);

   localparam int RAM_AW = $clog2(DEPTH);
   localparam logic signed [ACC_W-1:0] LANE_MAX = ACC_W'(INT8_MAX);
   localparam logic signed [ACC_W-1:0] LANE_MIN = ACC_W'(INT8_MIN);

   typedef logic [LANES-1:0][ACC_W-1:0] acc_vec_t;

   function automatic logic [ACC_W-1:0] sext(input logic [DATA_W-1:0] v);
      return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
   endfunction

   function automatic logic [DATA_W-1:0] sat_lane(input logic signed [ACC_W-1:0] v,
                                                  input logic relu);
      if (relu && (v < 0)) return '0;
      if (v > LANE_MAX)    return LANE_MAX[DATA_W-1:0];
      if (v < LANE_MIN)    return LANE_MIN[DATA_W-1:0];
      return v[DATA_W-1:0];
   endfunction

   state_t            state;
   logic [11:0]       beats_q, chans_q, beat_cnt, ch_cnt;
   logic [ADDR_W-1:0] base_q;
   logic              relu_q, drain_cnt;
   logic              accept, last_beat, last_chan, cfg_bad, err_set;
   logic              vld_p0, first_p0, last_p0, fwd_p0, wr_en;
   logic [11:0]       beat_p0;
   acc_vec_t          psum_p0, sum_hold, rd_data, rd_val, sum;
   logic [LANES*DATA_W-1:0] din_next;

   assign accept    = psum_vld && (state == ST_ACCUM);
   assign last_beat = (beat_cnt == beats_q - 12'd1);
   assign last_chan = (ch_cnt == chans_q - 12'd1);
   assign cfg_bad   = (cfg_beats == 12'd0) || (cfg_channel == 12'd0) ||
                      ({20'd0, cfg_beats} > DEPTH);
   // The final channel never feeds the buffer again, so it skips the write
   assign wr_en     = vld_p0 && !last_p0;

   // Protocol error sources, all folded into the sticky err flag
   always_comb begin
      err_set = 1'b0;
      if (accept && (channel_end != last_beat))   err_set = 1'b1;
      if (psum_vld && (state != ST_ACCUM))        err_set = 1'b1;
      if (init_signal && busy)                    err_set = 1'b1;
   end

   // Layer sequencing: config latch, beat/channel counters, drain timing and status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         beats_q    <= '0;
         chans_q    <= '0;
         base_q     <= '0;
         relu_q     <= 1'b0;
         beat_cnt   <= '0;
         ch_cnt     <= '0;
         drain_cnt  <= 1'b0;
         busy       <= 1'b0;
         layer_done <= 1'b0;
         err        <= 1'b0;
      end else begin
         layer_done <= 1'b0;
         case (state)
            ST_IDLE: if (init_signal) begin
               beats_q  <= cfg_beats;
               chans_q  <= cfg_channel;
               base_q   <= cfg_base;
               relu_q   <= cfg_relu;
               beat_cnt <= '0;
               ch_cnt   <= '0;
               err      <= cfg_bad;
               if (cfg_bad) begin
                  state      <= ST_DONE;
                  layer_done <= 1'b1;
               end else begin
                  state <= ST_ACCUM;
                  busy  <= 1'b1;
               end
            end
            ST_ACCUM: if (accept) begin
               if (last_beat) begin
                  beat_cnt <= '0;
                  ch_cnt   <= ch_cnt + 12'd1;
                  if (last_chan) begin
                     state     <= ST_DRAIN;
                     drain_cnt <= 1'b0;
                  end
               end else begin
                  beat_cnt <= beat_cnt + 12'd1;
               end
            end
            ST_DRAIN: begin
               if (drain_cnt) begin
                  state      <= ST_DONE;
                  layer_done <= 1'b1;
                  busy       <= 1'b0;
               end
               drain_cnt <= 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
         if (err_set) err <= 1'b1;
      end
   end

   psum_acc_ram #(
      .DEPTH (DEPTH),
      .AW    (RAM_AW),
      .W     (LANES*ACC_W)
   ) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (beat_p0[RAM_AW-1:0]),
      .wdata (sum),
      .raddr (beat_cnt[RAM_AW-1:0]),
      .rdata (rd_data)
   );

   // Stage p0 -> add: forward the previous sum when the RAM read raced its write
   always_comb begin
      rd_val   = fwd_p0 ? sum_hold : rd_data;
      din_next = '0;
      for (int i = 0; i < LANES; i++) begin
         sum[i] = (first_p0 ? '0 : rd_val[i]) + psum_p0[i];
         din_next[i*DATA_W +: DATA_W] = sat_lane($signed(sum[i]), relu_q);
      end
   end

   // Pipeline control and BRAM output registers (stage p0 -> writeback)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p0    <= 1'b0;
         first_p0  <= 1'b0;
         last_p0   <= 1'b0;
         fwd_p0    <= 1'b0;
         bram_we   <= 4'h0;
         bram_addr <= '0;
         bram_din  <= '0;
      end else begin
         vld_p0   <= accept;
         first_p0 <= (ch_cnt == 12'd0);
         last_p0  <= last_chan;
         fwd_p0   <= accept && wr_en && (beat_p0[RAM_AW-1:0] == beat_cnt[RAM_AW-1:0]);
         bram_we  <= (vld_p0 && last_p0) ? 4'hF : 4'h0;
         if (vld_p0 && last_p0) begin
            bram_addr <= base_q + ADDR_W'({beat_p0, 2'b00});
            bram_din  <= din_next;
         end
      end
   end

   // Stage p0 data capture and the held sum used for forwarding
   always_ff @(posedge clk) begin
      if (accept) begin
         beat_p0    <= beat_cnt;
         psum_p0[0] <= sext(psum0);
         psum_p0[1] <= sext(psum1);
         psum_p0[2] <= sext(psum2);
         psum_p0[3] <= sext(psum3);
      end
      if (vld_p0) sum_hold <= sum;
   end

endmodule
